// File: rtl/dbg_guv_pkg.sv
// Shared encodings for the debug-governor control front-end: command FSM states,
// shadow register map, response layout and control-code helpers.
package dbg_guv_pkg;

  typedef enum logic {
    CMD_FSM_ADDR = 1'b0,
    CMD_FSM_DATA = 1'b1
  } cmd_fsm_t;

  // Register selector is 4 bits wide; REG_ADDR_WIDTH must be at least 4.
  typedef enum logic [3:0] {
    REG_DROP_CNT      = 4'd0,
    REG_LOG_CNT       = 4'd1,
    REG_INJ_TDATA     = 4'd2,
    REG_INJ_TVALID    = 4'd3,
    REG_INJ_TLAST     = 4'd4,
    REG_INJ_TKEEP     = 4'd5,
    REG_INJ_TDEST     = 4'd6,
    REG_INJ_TID       = 4'd7,
    REG_KEEP_PAUSING  = 4'd8,
    REG_KEEP_LOGGING  = 4'd9,
    REG_KEEP_DROPPING = 4'd10
  } reg_sel_t;

  localparam int REG_LAST = 10;

  localparam int RESP_FLITS = 4;

  localparam int FLIT0_KEEP_PAUSING  = 0;
  localparam int FLIT0_KEEP_LOGGING  = 1;
  localparam int FLIT0_KEEP_DROPPING = 2;
  localparam int FLIT0_INJ_TVALID    = 3;
  localparam int FLIT0_PAUSE         = 4;
  localparam int FLIT0_OVERFLOW      = 5;
  localparam int FLIT0_ADDR_LSB      = 8;

  function automatic logic [31:0] reg_commit(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] reg_readback(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/dbg_guv_resp_snap.sv
// Readback snapshot and AXIS serializer: captures live governor state on request
// and emits it as a fixed four-flit response, tracking dropped requests.
module dbg_guv_resp_snap
  import dbg_guv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_SIZE   = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_readback,
  input  logic                  i_keep_pausing,
  input  logic                  i_keep_logging,
  input  logic                  i_keep_dropping,
  input  logic                  i_inj_vld,
  input  logic                  i_pause,
  input  logic [CNT_SIZE-1:0]   i_drop_cnt,
  input  logic [CNT_SIZE-1:0]   i_log_cnt,
  input  logic [DATA_WIDTH-1:0] i_pass_cnt,
  input  logic                  i_resp_rdy,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_resp_vld,
  output logic                  o_resp_last
);

  logic [DATA_WIDTH-1:0] r_flit [RESP_FLITS];
  logic [1:0]            r_idx;
  logic                  r_busy;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] w_flit0;
  logic                  w_hs;
  logic                  w_last;

  always_comb begin
    w_flit0 = '0;
    w_flit0[FLIT0_ADDR_LSB +: ADDR_WIDTH] = ADDR_WIDTH'(ADDR);
    w_flit0[FLIT0_OVERFLOW]      = r_ovf;
    w_flit0[FLIT0_PAUSE]         = i_pause;
    w_flit0[FLIT0_INJ_TVALID]    = i_inj_vld;
    w_flit0[FLIT0_KEEP_DROPPING] = i_keep_dropping;
    w_flit0[FLIT0_KEEP_LOGGING]  = i_keep_logging;
    w_flit0[FLIT0_KEEP_PAUSING]  = i_keep_pausing;
  end

  assign w_hs   = r_busy && i_resp_rdy;
  assign w_last = (r_idx == 2'(RESP_FLITS - 1));

  // Snapshot / serializer stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < RESP_FLITS; i++) r_flit[i] <= '0;
    end else begin
      if (i_readback && !r_busy) begin
        r_flit[0] <= w_flit0;
        r_flit[1] <= DATA_WIDTH'(i_drop_cnt);
        r_flit[2] <= DATA_WIDTH'(i_log_cnt);
        r_flit[3] <= i_pass_cnt;
        r_busy    <= 1'b1;
        r_idx     <= '0;
      end else if (w_hs) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
      // The flag is cleared only by the flit0 that actually reported it; a new drop wins.
      if (i_readback && r_busy)
        r_ovf <= 1'b1;
      else if (w_hs && r_idx == 2'd0 && r_flit[0][FLIT0_OVERFLOW])
        r_ovf <= 1'b0;
    end
  end

  assign o_resp_data = r_busy ? r_flit[r_idx] : '0;
  assign o_resp_vld  = r_busy;
  assign o_resp_last = r_busy && w_last;

endmodule

// File: rtl/dbg_guv_ctl.sv
// Debug-governor control front-end: decodes the daisy-chained command stream into
// shadow registers, commits them to live governor controls and serves readbacks.
module dbg_guv_ctl
  import dbg_guv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEST_WIDTH     = 16,
  parameter int ID_WIDTH       = 16,
  parameter int CNT_SIZE       = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int ADDR           = 0,
  parameter int PIPE_STAGE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   cmd_in_TDATA,
  input  logic                    cmd_in_TVALID,
  output logic                    cmd_in_TREADY,
  output logic [DATA_WIDTH-1:0]   cmd_out_TDATA,
  output logic                    cmd_out_TVALID,
  input  logic                    cmd_out_TREADY,
  input  logic                    in_flit,
  input  logic                    log_flit,
  input  logic                    out_flit,
  output logic [DATA_WIDTH-1:0]   inj_TDATA,
  output logic                    inj_TVALID,
  input  logic                    inj_TREADY,
  output logic [DATA_WIDTH/8-1:0] inj_TKEEP,
  output logic [DEST_WIDTH-1:0]   inj_TDEST,
  output logic [ID_WIDTH-1:0]     inj_TID,
  output logic                    inj_TLAST,
  output logic                    pause,
  output logic                    drop,
  output logic                    log_en,
  output logic [DATA_WIDTH-1:0]   resp_TDATA,
  output logic                    resp_TVALID,
  input  logic                    resp_TREADY,
  output logic                    resp_TLAST
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam logic [REG_ADDR_WIDTH-1:0] L_REG_COMMIT   = REG_ADDR_WIDTH'(reg_commit(REG_ADDR_WIDTH));
  localparam logic [REG_ADDR_WIDTH-1:0] L_REG_READBACK = REG_ADDR_WIDTH'(reg_readback(REG_ADDR_WIDTH));
  localparam logic [REG_ADDR_WIDTH-1:0] L_REG_LAST     = REG_ADDR_WIDTH'(REG_LAST);
  localparam logic [ADDR_WIDTH-1:0]     L_CORE         = ADDR_WIDTH'(ADDR);

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_SIZE-1:0] dec_to_zero(input logic [CNT_SIZE-1:0] v,
                                                       input logic            en);
    return (en && v != '0) ? v - 1'b1 : v;
  endfunction

  logic [ADDR_WIDTH-1:0]     w_core;
  logic [REG_ADDR_WIDTH-1:0] w_reg;
  logic                      w_acc;
  logic                      w_for_me;
  logic                      w_fwd;
  cmd_fsm_t                  r_state;
  cmd_fsm_t                  w_state_nxt;
  reg_sel_t                  r_reg_sel;
  logic                      w_commit;
  logic                      w_readback;
  logic                      w_sel_wr;
  logic                      w_data_wr;

  logic [CNT_SIZE-1:0]   r_sh_drop_cnt, r_sh_log_cnt;
  logic [DATA_WIDTH-1:0] r_sh_inj_data;
  logic                  r_sh_inj_vld, r_sh_inj_last;
  logic [KEEP_W-1:0]     r_sh_inj_keep;
  logic [DEST_WIDTH-1:0] r_sh_inj_dest;
  logic [ID_WIDTH-1:0]   r_sh_inj_id;
  logic                  r_sh_keep_pausing, r_sh_keep_logging, r_sh_keep_dropping;

  logic [CNT_SIZE-1:0]   r_drop_cnt, r_log_cnt;
  logic [DATA_WIDTH-1:0] r_inj_data;
  logic                  r_inj_vld, r_inj_last;
  logic [KEEP_W-1:0]     r_inj_keep;
  logic [DEST_WIDTH-1:0] r_inj_dest;
  logic [ID_WIDTH-1:0]   r_inj_id;
  logic                  r_keep_pausing, r_keep_logging, r_keep_dropping;
  logic [DATA_WIDTH-1:0] r_pass_cnt;
  logic                  w_pause;

  assign w_core   = cmd_in_TDATA[ADDR_WIDTH+REG_ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign w_reg    = cmd_in_TDATA[REG_ADDR_WIDTH-1:0];
  assign w_acc    = cmd_in_TVALID && cmd_in_TREADY;
  assign w_for_me = (w_core == L_CORE);
  // A data flit belongs to this core regardless of its bit pattern.
  assign w_fwd    = (r_state == CMD_FSM_ADDR) && !w_for_me;

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_readback  = 1'b0;
    w_sel_wr    = 1'b0;
    w_data_wr   = 1'b0;
    if (w_acc) begin
      case (r_state)
        CMD_FSM_ADDR: begin
          if (w_for_me) begin
            if (w_reg == L_REG_COMMIT) begin
              w_commit = 1'b1;
            end else if (w_reg == L_REG_READBACK) begin
              w_readback = 1'b1;
            end else if (w_reg <= L_REG_LAST) begin
              w_sel_wr    = 1'b1;
              w_state_nxt = CMD_FSM_DATA;
            end
          end
        end
        CMD_FSM_DATA: begin
          w_data_wr   = 1'b1;
          w_state_nxt = CMD_FSM_ADDR;
        end
        default: w_state_nxt = CMD_FSM_ADDR;
      endcase
    end
  end

  // Command decode stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CMD_FSM_ADDR;
      r_reg_sel <= REG_DROP_CNT;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_wr) r_reg_sel <= reg_sel_t'(w_reg[3:0]);
    end
  end

  generate
    if (PIPE_STAGE != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] r_cmd_data;
      logic                  r_cmd_vld;
      // Forwarding stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cmd_vld  <= 1'b0;
          r_cmd_data <= '0;
        end else if (w_acc) begin
          r_cmd_vld <= w_fwd;
          if (w_fwd) r_cmd_data <= cmd_in_TDATA;
        end else if (cmd_out_TREADY) begin
          r_cmd_vld <= 1'b0;
        end
      end
      assign cmd_in_TREADY  = !r_cmd_vld || cmd_out_TREADY;
      assign cmd_out_TVALID = r_cmd_vld;
      assign cmd_out_TDATA  = r_cmd_data;
    end else begin : g_comb
      assign cmd_in_TREADY  = cmd_out_TREADY;
      assign cmd_out_TVALID = cmd_in_TVALID && w_fwd;
      assign cmd_out_TDATA  = cmd_in_TDATA;
    end
  endgenerate

  // Shadow register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_drop_cnt      <= '0;
      r_sh_log_cnt       <= '0;
      r_sh_inj_data      <= '0;
      r_sh_inj_vld       <= 1'b0;
      r_sh_inj_last      <= 1'b0;
      r_sh_inj_keep      <= '0;
      r_sh_inj_dest      <= '0;
      r_sh_inj_id        <= '0;
      r_sh_keep_pausing  <= 1'b0;
      r_sh_keep_logging  <= 1'b0;
      r_sh_keep_dropping <= 1'b0;
    end else if (w_data_wr) begin
      case (r_reg_sel)
        REG_DROP_CNT:      r_sh_drop_cnt      <= cmd_in_TDATA[CNT_SIZE-1:0];
        REG_LOG_CNT:       r_sh_log_cnt       <= cmd_in_TDATA[CNT_SIZE-1:0];
        REG_INJ_TDATA:     r_sh_inj_data      <= cmd_in_TDATA;
        REG_INJ_TVALID:    r_sh_inj_vld       <= cmd_in_TDATA[0];
        REG_INJ_TLAST:     r_sh_inj_last      <= cmd_in_TDATA[0];
        REG_INJ_TKEEP:     r_sh_inj_keep      <= cmd_in_TDATA[KEEP_W-1:0];
        REG_INJ_TDEST:     r_sh_inj_dest      <= cmd_in_TDATA[DEST_WIDTH-1:0];
        REG_INJ_TID:       r_sh_inj_id        <= cmd_in_TDATA[ID_WIDTH-1:0];
        REG_KEEP_PAUSING:  r_sh_keep_pausing  <= cmd_in_TDATA[0];
        REG_KEEP_LOGGING:  r_sh_keep_logging  <= cmd_in_TDATA[0];
        REG_KEEP_DROPPING: r_sh_keep_dropping <= cmd_in_TDATA[0];
        default: ;
      endcase
    end else if (w_commit) begin
      // One-shot fields are consumed by a commit; persistent modes and payload stay.
      r_sh_drop_cnt <= '0;
      r_sh_log_cnt  <= '0;
      r_sh_inj_vld  <= 1'b0;
    end
  end

  // Live control stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt      <= '0;
      r_log_cnt       <= '0;
      r_inj_data      <= '0;
      r_inj_vld       <= 1'b0;
      r_inj_last      <= 1'b0;
      r_inj_keep      <= '0;
      r_inj_dest      <= '0;
      r_inj_id        <= '0;
      r_keep_pausing  <= 1'b0;
      r_keep_logging  <= 1'b0;
      r_keep_dropping <= 1'b0;
      r_pass_cnt      <= '0;
    end else begin
      if (w_commit) begin
        r_drop_cnt      <= r_sh_drop_cnt;
        r_log_cnt       <= r_sh_log_cnt;
        r_inj_data      <= r_sh_inj_data;
        r_inj_vld       <= r_sh_inj_vld;
        r_inj_last      <= r_sh_inj_last;
        r_inj_keep      <= r_sh_inj_keep;
        r_inj_dest      <= r_sh_inj_dest;
        r_inj_id        <= r_sh_inj_id;
        r_keep_pausing  <= r_sh_keep_pausing;
        r_keep_logging  <= r_sh_keep_logging;
        r_keep_dropping <= r_sh_keep_dropping;
      end else begin
        r_drop_cnt <= dec_to_zero(r_drop_cnt, in_flit);
        r_log_cnt  <= dec_to_zero(r_log_cnt, log_flit);
        if (r_inj_vld && inj_TREADY) r_inj_vld <= 1'b0;
      end
      if (out_flit) r_pass_cnt <= sat_inc(r_pass_cnt);
    end
  end

  assign w_pause    = r_keep_pausing && r_drop_cnt == '0 && r_log_cnt == '0;
  assign pause      = w_pause;
  assign log_en     = r_keep_logging || r_log_cnt != '0;
  assign drop       = r_keep_dropping || r_drop_cnt != '0;
  assign inj_TDATA  = r_inj_data;
  assign inj_TVALID = r_inj_vld;
  assign inj_TKEEP  = r_inj_keep;
  assign inj_TDEST  = r_inj_dest;
  assign inj_TID    = r_inj_id;
  assign inj_TLAST  = r_inj_last;

  dbg_guv_resp_snap #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_SIZE   (CNT_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR       (ADDR)
  ) u_resp_snap (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_readback      (w_readback),
    .i_keep_pausing  (r_keep_pausing),
    .i_keep_logging  (r_keep_logging),
    .i_keep_dropping (r_keep_dropping),
    .i_inj_vld       (r_inj_vld),
    .i_pause         (w_pause),
    .i_drop_cnt      (r_drop_cnt),
    .i_log_cnt       (r_log_cnt),
    .i_pass_cnt      (r_pass_cnt),
    .i_resp_rdy      (resp_TREADY),
    .o_resp_data     (resp_TDATA),
    .o_resp_vld      (resp_TVALID),
    .o_resp_last     (resp_TLAST)
  );

endmodule

// File: tb/tb_dbg_guv_ctl.sv
// Directed bench for dbg_guv_ctl: programming, commit, counters, forwarding,
// readback with stalls, overflow reporting and reset recovery.
module tb_dbg_guv_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_in_TDATA;
  logic        cmd_in_TVALID;
  logic        cmd_in_TREADY;
  logic [31:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic        cmd_out_TREADY;
  logic        in_flit, log_flit, out_flit;
  logic [31:0] inj_TDATA;
  logic        inj_TVALID;
  logic        inj_TREADY;
  logic [3:0]  inj_TKEEP;
  logic [15:0] inj_TDEST;
  logic [15:0] inj_TID;
  logic        inj_TLAST;
  logic        pause, drop, log_en;
  logic [31:0] resp_TDATA;
  logic        resp_TVALID;
  logic        resp_TREADY;
  logic        resp_TLAST;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_fwd = 0;
  logic [31:0] fwd_data = '0;

  always #5 clk = ~clk;

  dbg_guv_ctl dut (
    .clk(clk), .rst(rst),
    .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID), .cmd_in_TREADY(cmd_in_TREADY),
    .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID), .cmd_out_TREADY(cmd_out_TREADY),
    .in_flit(in_flit), .log_flit(log_flit), .out_flit(out_flit),
    .inj_TDATA(inj_TDATA), .inj_TVALID(inj_TVALID), .inj_TREADY(inj_TREADY),
    .inj_TKEEP(inj_TKEEP), .inj_TDEST(inj_TDEST), .inj_TID(inj_TID), .inj_TLAST(inj_TLAST),
    .pause(pause), .drop(drop), .log_en(log_en),
    .resp_TDATA(resp_TDATA), .resp_TVALID(resp_TVALID), .resp_TREADY(resp_TREADY),
    .resp_TLAST(resp_TLAST)
  );

  always @(negedge clk) begin
    if (!rst && cmd_out_TVALID && cmd_out_TREADY) begin
      n_fwd    = n_fwd + 1;
      fwd_data = cmd_out_TDATA;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int i;
    cmd_in_TDATA  = d;
    cmd_in_TVALID = 1'b1;
    for (i = 0; i < 20; i++) begin
      if (cmd_in_TREADY) break;
      tick();
    end
    if (!cmd_in_TREADY) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed cmd_in_TREADY 0 expected 1");
    end
    tick();
    cmd_in_TVALID = 1'b0;
  endtask

  task automatic drain(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    resp_TREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_vld", resp_TVALID, 1'b1);
      chk("drain_data", resp_TDATA, e[k]);
      chk("drain_last", resp_TLAST, (k == 3));
      tick();
    end
    chk("drain_idle", resp_TVALID, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_rb [4];
    rst = 1'b1;
    cmd_in_TDATA = '0; cmd_in_TVALID = 1'b0; cmd_out_TREADY = 1'b1;
    in_flit = 1'b0; log_flit = 1'b0; out_flit = 1'b0;
    inj_TREADY = 1'b0; resp_TREADY = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pause", pause, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_log_en", log_en, 1'b0);
    chk("rst_inj_vld", inj_TVALID, 1'b0);
    chk("rst_inj_data", inj_TDATA, 32'h0);
    chk("rst_resp_vld", resp_TVALID, 1'b0);
    chk("rst_cmd_out_vld", cmd_out_TVALID, 1'b0);
    chk("rst_cmd_in_rdy", cmd_in_TREADY, 1'b1);

    for (int p = 0; p < 3; p++) begin
      out_flit = 1'b1; tick(); out_flit = 1'b0; tick();
    end

    // Single-flit inject
    inj_TREADY = 1'b1;
    send(32'h3); send(32'h1);
    send(32'h2); send(32'hDEADBEEF);
    chk("inj_precommit", inj_TVALID, 1'b0);
    send(32'hF);
    chk("inj_vld_commit", inj_TVALID, 1'b1);
    chk("inj_data", inj_TDATA, 32'hDEADBEEF);
    chk("inj_last", inj_TLAST, 1'b0);
    tick();
    chk("inj_vld_cleared", inj_TVALID, 1'b0);
    send(32'hF);
    chk("inj_shadow_vld", inj_TVALID, 1'b0);
    chk("inj_payload_kept", inj_TDATA, 32'hDEADBEEF);

    // Drop counter with keep_pausing
    send(32'h0); send(32'h3);
    send(32'h8); send(32'h1);
    send(32'hF);
    chk("drop_commit", drop, 1'b1);
    chk("pause_while_drop", pause, 1'b0);
    chk("log_en_off", log_en, 1'b0);
    for (int p = 0; p < 5; p++) begin
      chk("drop_before_pulse", drop, (p < 3));
      in_flit = 1'b1; tick(); in_flit = 1'b0;
    end
    chk("drop_done", drop, 1'b0);
    chk("pause_after_drop", pause, 1'b1);

    // Forwarding with downstream backpressure
    cmd_out_TREADY = 1'b0;
    send(32'h13);
    chk("fwd_vld", cmd_out_TVALID, 1'b1);
    chk("fwd_data", cmd_out_TDATA, 32'h13);
    chk("fwd_in_rdy_low", cmd_in_TREADY, 1'b0);
    tick();
    chk("fwd_hold_vld", cmd_out_TVALID, 1'b1);
    chk("fwd_hold_rdy", cmd_in_TREADY, 1'b0);
    cmd_out_TREADY = 1'b1;
    #1;
    chk("fwd_in_rdy_high", cmd_in_TREADY, 1'b1);
    tick();
    chk("fwd_drained", cmd_out_TVALID, 1'b0);
    chk("fwd_count", n_fwd, 1);
    chk("fwd_seen_data", fwd_data, 32'h13);

    // log_cnt readback under a toggling ready
    send(32'h1); send(32'h2);
    send(32'hF);
    chk("log_en_cnt", log_en, 1'b1);
    chk("pause_while_log", pause, 1'b0);
    resp_TREADY = 1'b0;
    send(32'hE);
    exp_rb[0] = 32'h1; exp_rb[1] = 32'h0; exp_rb[2] = 32'h2; exp_rb[3] = 32'h3;
    for (int k = 0; k < 4; k++) begin
      chk("rb_vld", resp_TVALID, 1'b1);
      chk("rb_data", resp_TDATA, exp_rb[k]);
      chk("rb_last", resp_TLAST, (k == 3));
      resp_TREADY = 1'b0; tick();
      chk("rb_stall_data", resp_TDATA, exp_rb[k]);
      chk("rb_stall_last", resp_TLAST, (k == 3));
      resp_TREADY = 1'b1; tick();
    end
    chk("rb_idle", resp_TVALID, 1'b0);

    // Overflow reporting
    resp_TREADY = 1'b0;
    send(32'hE); send(32'hE);
    drain(32'h01, 32'h0, 32'h2, 32'h3);
    send(32'hE);
    drain(32'h21, 32'h0, 32'h2, 32'h3);
    send(32'hE);
    drain(32'h01, 32'h0, 32'h2, 32'h3);

    for (int p = 0; p < 3; p++) begin
      log_flit = 1'b1; tick(); log_flit = 1'b0;
    end
    chk("log_en_done", log_en, 1'b0);
    chk("pause_after_log", pause, 1'b1);

    // Reset while waiting for a data flit
    send(32'h2);
    rst = 1'b1; tick();
    chk("rstd_pause", pause, 1'b0);
    chk("rstd_inj_data", inj_TDATA, 32'h0);
    chk("rstd_cmd_out", cmd_out_TVALID, 1'b0);
    rst = 1'b0;
    send(32'h9); send(32'h1);
    send(32'hF);
    chk("rstd_addr_decoded", log_en, 1'b1);
    chk("rstd_inj_untouched", inj_TDATA, 32'h0);

    // Reset while a response is in flight
    resp_TREADY = 1'b0;
    send(32'hE);
    chk("rstr_busy", resp_TVALID, 1'b1);
    rst = 1'b1; tick();
    chk("rstr_resp_vld", resp_TVALID, 1'b0);
    chk("rstr_resp_data", resp_TDATA, 32'h0);
    chk("rstr_log_en", log_en, 1'b0);
    rst = 1'b0;
    out_flit = 1'b1; tick(); out_flit = 1'b0;
    send(32'hE);
    drain(32'h0, 32'h0, 32'h0, 32'h1);

    chk("fwd_count_final", n_fwd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
